// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared types and constants for the word-copy DMA engine.
package mem_dma_pkg;

   // Byte stride between consecutive 32-bit words.
   localparam int WORD_BYTES = 4;

   // Width of every memory byte address and pointer.
   localparam int ADDR_W = 32;

   // Top-level FSM states; the encoding is fixed so it can be mirrored by
   // plain localparam constants inside the engine.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } mem_dma_state_e;

   // A byte address is word aligned when its two low bits are zero.
   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_dma.sv
// mem_dma: copies len 32-bit words from src_addr to dst_addr, one read and
// one write per word, in strictly ascending word order. Misaligned requests
// are rejected with err alongside done. Every output is a register loaded
// from the next-state decode, so the bus sees clean Moore-style values and an
// asynchronous reset clears them immediately.
module mem_dma
   import mem_dma_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       src_addr,
   input  logic [31:0]       dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'(IDLE);
   localparam logic [1:0] ST_READ  = 2'(READ);
   localparam logic [1:0] ST_WRITE = 2'(WRITE);
   localparam logic [1:0] ST_DONE  = 2'(DONE);

   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);
   localparam logic [LEN_W-1:0]  CNT_ZERO  = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0]  CNT_ONE   = LEN_W'(1);

   // Architectural state.
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_src_ptr;
   logic [ADDR_W-1:0] r_dst_ptr;
   logic [LEN_W-1:0]  r_cnt;
   logic [31:0]       r_buf;
   logic              r_err_flag;

   // Registered outputs.
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [31:0]       r_mem_addr;
   logic [31:0]       r_mem_wdata;

   // Next-state values.
   logic [1:0]        w_state_nx;
   logic [ADDR_W-1:0] w_src_nx;
   logic [ADDR_W-1:0] w_dst_nx;
   logic [LEN_W-1:0]  w_cnt_nx;
   logic [31:0]       w_buf_nx;
   logic              w_err_flag_nx;
   logic              w_misaligned;

   // Next output values, decoded from the next state.
   logic              w_busy_nx;
   logic              w_done_nx;
   logic              w_err_nx;
   logic              w_mem_rd_nx;
   logic              w_mem_wr_nx;
   logic [31:0]       w_mem_addr_nx;
   logic [31:0]       w_mem_wdata_nx;

   assign w_misaligned = !is_word_aligned(src_addr[1:0]) ||
                         !is_word_aligned(dst_addr[1:0]);

   // FSM transitions and datapath updates (pointers, counter, data buffer).
   always_comb begin
      w_state_nx    = r_state;
      w_src_nx      = r_src_ptr;
      w_dst_nx      = r_dst_ptr;
      w_cnt_nx      = r_cnt;
      w_buf_nx      = r_buf;
      w_err_flag_nx = r_err_flag;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_src_nx = src_addr;
               w_dst_nx = dst_addr;
               w_cnt_nx = len;
               if (w_misaligned) begin
                  w_state_nx    = ST_DONE;
                  w_err_flag_nx = 1'b1;
               end else if (len == CNT_ZERO) begin
                  w_state_nx    = ST_DONE;
                  w_err_flag_nx = 1'b0;
               end else begin
                  w_state_nx    = ST_READ;
                  w_err_flag_nx = 1'b0;
               end
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_READ: begin
            // Memory read data is combinational, so it is valid this cycle.
            w_buf_nx   = mem_rdata;
            w_state_nx = ST_WRITE;
         end
         ST_WRITE: begin
            // Pointers wrap modulo 2^32 by plain unsigned overflow.
            w_src_nx = r_src_ptr + WORD_STEP;
            w_dst_nx = r_dst_ptr + WORD_STEP;
            w_cnt_nx = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
               w_state_nx = ST_DONE;
            end else begin
               w_state_nx = ST_READ;
            end
         end
         ST_DONE: begin
            w_state_nx    = ST_IDLE;
            w_err_flag_nx = 1'b0;
         end
         default: begin
            w_state_nx    = ST_IDLE;
            w_err_flag_nx = 1'b0;
         end
      endcase
   end

   // Output decode from the next state, so the output registers present the
   // values that belong to the state being entered.
   always_comb begin
      w_busy_nx      = (w_state_nx != ST_IDLE);
      w_done_nx      = (w_state_nx == ST_DONE);
      w_err_nx       = (w_state_nx == ST_DONE) && w_err_flag_nx;
      w_mem_rd_nx    = 1'b0;
      w_mem_wr_nx    = 1'b0;
      w_mem_addr_nx  = 32'h0000_0000;
      w_mem_wdata_nx = 32'h0000_0000;
      case (w_state_nx)
         ST_READ: begin
            w_mem_rd_nx   = 1'b1;
            w_mem_addr_nx = w_src_nx;
         end
         ST_WRITE: begin
            w_mem_wr_nx    = 1'b1;
            w_mem_addr_nx  = w_dst_nx;
            w_mem_wdata_nx = w_buf_nx;
         end
         default: begin
            w_mem_rd_nx    = 1'b0;
            w_mem_wr_nx    = 1'b0;
            w_mem_addr_nx  = 32'h0000_0000;
            w_mem_wdata_nx = 32'h0000_0000;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transfer in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_src_ptr  <= 32'h0000_0000;
         r_dst_ptr  <= 32'h0000_0000;
         r_cnt      <= CNT_ZERO;
         r_buf      <= 32'h0000_0000;
         r_err_flag <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_src_ptr  <= w_src_nx;
         r_dst_ptr  <= w_dst_nx;
         r_cnt      <= w_cnt_nx;
         r_buf      <= w_buf_nx;
         r_err_flag <= w_err_flag_nx;
      end
   end

   // Output registers; reset drops a pending write before it reaches memory.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= 32'h0000_0000;
         r_mem_wdata <= 32'h0000_0000;
      end else begin
         r_busy      <= w_busy_nx;
         r_done      <= w_done_nx;
         r_err       <= w_err_nx;
         r_mem_rd    <= w_mem_rd_nx;
         r_mem_wr    <= w_mem_wr_nx;
         r_mem_addr  <= w_mem_addr_nx;
         r_mem_wdata <= w_mem_wdata_nx;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: randomized self-checking bench for mem_dma. A 128-word memory
// sits on the DMA port; a reference model performs the copy word by word in
// ascending order and predicts done/err timing and access counts.
module tb_mem_dma;

   localparam int LEN_W     = 8;
   localparam int MEM_WORDS = 128;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [31:0]       src_addr;
   logic [31:0]       dst_addr;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic              err;
   logic              mem_rd;
   logic              mem_wr;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [31:0] mem     [0:MEM_WORDS-1];
   logic [31:0] exp_mem [0:MEM_WORDS-1];
   logic        bd_we = 1'b0;
   logic [6:0]  bd_idx = 7'd0;
   logic [31:0] bd_data = 32'h0;
   logic [31:0] rd_log [$];

   int n_tests = 0;
   int n_fail  = 0;

   mem_dma #(.LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .err(err),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic in_range(input logic [31:0] a);
      return a < 32'(MEM_WORDS * 4);
   endfunction

   assign mem_rdata = in_range(mem_addr) ? mem[mem_addr[8:2]] : 32'h0;

   // Memory: backdoor preload port has priority over the DMA write port.
   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      else if (mem_wr && in_range(mem_addr)) mem[mem_addr[8:2]] <= mem_wdata;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
      end
   endtask

   task automatic load_mem();
      for (int i = 0; i < MEM_WORDS; i++) begin
         @(negedge clk);
         bd_we = 1'b1; bd_idx = 7'(i); bd_data = exp_mem[i];
      end
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < MEM_WORDS; i++) exp_mem[i] = $urandom;
      load_mem();
   endtask

   // Reference copy: ascending word order, out-of-range reads give 0 and
   // out-of-range writes vanish.
   task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
      logic [31:0] s, d, v;
      for (int i = 0; i < n; i++) begin
         s = src + 32'(4 * i);
         d = dst + 32'(4 * i);
         v = in_range(s) ? exp_mem[s[8:2]] : 32'h0;
         if (in_range(d)) exp_mem[d[8:2]] = v;
      end
   endtask

   task automatic check_mem(input string tag);
      int diffs = 0;
      for (int i = 0; i < MEM_WORDS; i++) begin
         if (mem[i] !== exp_mem[i]) begin
            if (diffs == 0) $display("  first differing word %0d: 0x%08h vs 0x%08h", i, mem[i], exp_mem[i]);
            diffs++;
         end
      end
      check_eq(tag, 32'(diffs), 32'd0);
   endtask

   task automatic do_xfer(input logic [31:0] src, input logic [31:0] dst, input int n, input bit noise);
      bit acc_err;
      int exp_done, exp_acc, done_cyc, ndone, nrd, nwr, busy_low;
      logic err_seen;
      acc_err  = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
      exp_done = (acc_err || n == 0) ? 1 : 2 * n + 1;
      exp_acc  = (acc_err || n == 0) ? 0 : n;
      if (!acc_err) model_copy(src, dst, n);
      rd_log.delete();
      done_cyc = -1; ndone = 0; nrd = 0; nwr = 0; busy_low = 0; err_seen = 1'b0;
      @(negedge clk);
      start = 1'b1; src_addr = src; dst_addr = dst; len = LEN_W'(n);
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= exp_done + 4; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (done_cyc < 0) begin done_cyc = c; err_seen = err; end
         end
         if (mem_rd) begin
            check_eq("rd_addr", mem_addr, src + 32'(4 * nrd));
            rd_log.push_back(mem_addr);
            nrd++;
         end
         if (mem_wr) begin
            check_eq("wr_addr", mem_addr, dst + 32'(4 * nwr));
            nwr++;
         end
         check_eq("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
         if (!mem_rd && !mem_wr) check_eq("idle_bus", mem_addr | mem_wdata, 32'd0);
         if (c <= exp_done && !busy) busy_low++;
         if (c == exp_done + 1) check_eq("busy_fall", 32'(busy), 32'd0);
         if (noise && c <= exp_done) begin
            start = 1'b1; src_addr = 32'h100; dst_addr = 32'h180; len = 8'd5;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check_eq("done_cycle", 32'(done_cyc), 32'(exp_done));
      check_eq("done_count", 32'(ndone), 32'd1);
      check_eq("err", 32'(err_seen), 32'(acc_err));
      check_eq("busy_high", 32'(busy_low), 32'd0);
      check_eq("rd_count", 32'(nrd), 32'(exp_acc));
      check_eq("wr_count", 32'(nwr), 32'(exp_acc));
      check_mem("mem_contents");
   endtask

   initial begin
      logic [31:0] rs, rdst;
      int rn;
      reset = 1'b1; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; len = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset_ctl", {27'd0, busy, done, err, mem_rd, mem_wr}, 32'd0);
      check_eq("reset_addr", mem_addr, 32'd0);
      check_eq("reset_wdata", mem_wdata, 32'd0);
      reset = 1'b0;

      // Basic copy.
      for (int i = 0; i < MEM_WORDS; i++) exp_mem[i] = 32'h0;
      exp_mem[0] = 32'h11; exp_mem[1] = 32'h22; exp_mem[2] = 32'h33; exp_mem[3] = 32'h44;
      load_mem();
      do_xfer(32'h00, 32'h40, 4, 1'b0);
      check_eq("basic_w3", mem[19], 32'h44);

      // Zero length and misalignment.
      do_xfer(32'h10, 32'h80, 0, 1'b0);
      do_xfer(32'h02, 32'h40, 3, 1'b0);
      do_xfer(32'h00, 32'h41, 3, 1'b0);

      // Start during READ/WRITE/DONE is ignored.
      fill_random();
      do_xfer(32'h20, 32'h60, 2, 1'b1);

      // Overlapping copy.
      for (int i = 0; i < MEM_WORDS; i++) exp_mem[i] = 32'h0;
      for (int i = 0; i < 4; i++) exp_mem[i] = 32'(i + 1);
      load_mem();
      do_xfer(32'h00, 32'h04, 3, 1'b0);
      for (int i = 0; i < 4; i++) check_eq("overlap_word", mem[i], 32'd1);

      // Address wrap.
      fill_random();
      do_xfer(32'hFFFF_FFFC, 32'h40, 2, 1'b0);
      check_eq("wrap_rd_count", 32'(rd_log.size()), 32'd2);
      if (rd_log.size() >= 2) check_eq("wrap_rd2", rd_log[1], 32'h0);

      // Reset asserted mid-cycle during the write of word index 2.
      fill_random();
      @(negedge clk);
      start = 1'b1; src_addr = 32'h00; dst_addr = 32'h100; len = 8'd4;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_write", 32'(mem_wr), 32'd1);
      reset = 1'b1;
      #1;
      check_eq("rst_ctl", {27'd0, busy, done, err, mem_rd, mem_wr}, 32'd0);
      check_eq("rst_addr", mem_addr, 32'd0);
      check_eq("rst_wdata", mem_wdata, 32'd0);
      model_copy(32'h00, 32'h100, 2);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_mem("rst_partial");
      do_xfer(32'h08, 32'h140, 3, 1'b0);

      // Randomized transfers, some misaligned, some running off the memory.
      for (int t = 0; t < 14; t++) begin
         fill_random();
         rs   = {23'd0, 7'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
         rdst = {23'd0, 7'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
         rn   = $urandom_range(0, 12);
         if ($urandom_range(0, 7) == 0) rs   = rs   + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) rdst = rdst + 32'($urandom_range(1, 3));
         do_xfer(rs, rdst, rn, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_dma.md
# mem_dma

Word-copy engine that moves `len` 32-bit words from a source to a destination address in data memory. It acts as the initiator on the data-memory port (`rd`/`wr`/`addr`/`wdata`/`rdata`), issuing one read then one write per word. It sits beside the CPU on the data-memory bus; the bus mux grants the memory port to this block whenever `busy` is high.

## Interface

Clock is `clk`. Reset is `reset`, asynchronous and active-high.

Parameters:
- `LEN_W`, default 8: width of the word-count input; at most 2^LEN_W−1 words per transfer.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a transfer; sampled only in IDLE.
- `src_addr` in 32: source byte address; must be word aligned.
- `dst_addr` in 32: destination byte address; must be word aligned.
- `len` in LEN_W: number of words to copy.
- `busy` out 1: high in READ, WRITE and DONE.
- `done` out 1: one-cycle pulse at the end of every accepted request.
- `err` out 1: high together with `done` when the request was rejected for misalignment.
- `mem_rd` out 1: memory read enable.
- `mem_wr` out 1: memory write enable; memory writes on the posedge.
- `mem_addr` out 32: memory byte address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data; combinational, valid in the same cycle as `mem_rd`/`mem_addr`.

## Operation

- **FSM states:** IDLE, READ, WRITE, DONE.
- **IDLE + `start`:**
  - Latch `src_addr`, `dst_addr` and `len` into `src_ptr`, `dst_ptr` and `cnt`.
  - Go to DONE with the error flag set if `src_addr[1:0]` or `dst_addr[1:0]` is non-zero.
  - Otherwise go to DONE if `len`==0.
  - Otherwise go to READ.
- **READ:**
  - `mem_rd`=1 and `mem_addr`=`src_ptr`.
  - `mem_rdata` is captured into `buf` at the clock edge.
  - Next state is WRITE.
- **WRITE:**
  - `mem_wr`=1, `mem_addr`=`dst_ptr`, `mem_wdata`=`buf`.
  - At the edge: `src_ptr`+=4, `dst_ptr`+=4, `cnt`−=1.
  - Next state is DONE if `cnt`==1, else READ.
- **DONE:**
  - `done`=1.
  - `err`=error flag.
  - Next state is IDLE; the error flag clears.
- **Memory enables:** `mem_rd` and `mem_wr` are never high together. Both are Moore-decoded from state.
- **Idle bus values:** outside READ/WRITE, `mem_addr`=0 and `mem_wdata`=0.
- **Pointer arithmetic:** pointers are 32-bit and wrap modulo 2^32; there is no range check. Out-of-range addresses are the memory's concern; it returns 0 and drops writes.
- **Overlap:** overlapping regions are copied in strictly ascending word order. A destination inside the source range therefore propagates already-copied words.
- **`start` outside IDLE:** ignored, including `start` in the DONE cycle.
- **Reset mid-transfer:** returns to IDLE and clears all outputs immediately. A write that has not yet reached its edge is not performed, and the partial copy is left in memory.

## Timing

- **Reset values:** `busy`=0, `done`=0, `err`=0, `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0. State resets to IDLE; `cnt`, pointers and `buf` reset to 0.
- **Start edge:** `start` is sampled at edge E0 in IDLE. The first READ occupies the cycle after E0.
- **Throughput:** 2 cycles per word.
- **`done` timing:**
  - Valid request: `done` is high in cycle 2·len+1 after E0.
  - `len`=0 or misaligned request: `done` is high in cycle 1 after E0.
- **`busy`:** rises in the cycle after E0 and falls in the cycle after `done`.
- **Back-to-back transfers:** `start` may be re-asserted in the cycle after DONE (IDLE). The minimum gap between transfers is therefore one IDLE cycle.

## Structure

- **Package `mem_dma_pkg`:**
  - State enum `{IDLE, READ, WRITE, DONE}`.
  - `WORD_BYTES`=4.
  - `ADDR_W`=32.
- **Module:** a single module with no sub-module. The datapath is two pointer registers, a down-counter and a data buffer, around a 4-state FSM.

## Test plan

- **Basic copy:** preload words 0x00..0x0C = 11,22,33,44; start src=0x00 dst=0x40 len=4. Required: words 0x40..0x4C = 11,22,33,44, `done` 9 cycles after the start edge, `err`=0, exactly 4 `mem_rd` and 4 `mem_wr` cycles.
- **Zero length and misalignment:**
  - start len=0: `done` 1 cycle after the start edge, no memory accesses.
  - src=0x02, len=3: `done`=`err`=1 one cycle later, no accesses.
  - dst=0x41, len=3: same response as the misaligned source.
- **Ignored `start`:** pulse `start` with different args during READ, WRITE and DONE of a len=2 copy. Required: only the first transfer occurs, and `done` pulses exactly once.
- **Reset mid-transfer:** assert `reset` asynchronously mid-cycle during WRITE of word 2 of a len=4 copy. Required: outputs are 0 immediately, only 2 destination words are modified, and a fresh start afterwards works.
- **Overlapping copy:** preload 0x00..0x0C = 1,2,3,4; start src=0x00 dst=0x04 len=3. Required: words 0x00..0x0C = 1,1,1,1.
- **Address wrap:** src=0xFFFFFFFC, len=2. Required: the second read address is 0x00000000.
